// File: rtl/uart_tx_cfg.sv
// Purpose : configurable UART transmitter (5..9 data bits, optional parity, 1/2 stop bits).
// Latency : tx_pin falls on the clk edge that accepts tx_start; each bit lasts OVERSAMPLE ticks.
// Backpr. : tx_start is only accepted in IDLE (tx_busy low); requests while busy are dropped.
//
// Ports:
//   clk, reset           - rising-edge clock, asynchronous active-high reset
//   tick                 - one-clk oversample strobe from the baud generator
//   tx_start, tx_data    - frame request and payload (LSB first), sampled at accept
//   data_len             - data bits minus one (clamped to DATA_W-1)
//   parity_en/odd, stop2 - frame format, sampled at accept
//   tx_pin, tx_busy      - registered serial line and busy flag
//   tx_done              - registered one-clk pulse after the last stop tick
//
// Build option: define UART_TX_PARITY_EN to compile in the parity bit and PARITY state;
// otherwise parity_en/parity_odd are present but ignored.

module uart_tx_cfg #(
   parameter int DATA_W     = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tick,
   input  logic                      tx_start,
   input  logic [DATA_W-1:0]         tx_data,
   input  logic [$clog2(DATA_W)-1:0] data_len,
   input  logic                      parity_en,
   input  logic                      parity_odd,
   input  logic                      stop2,
   output logic                      tx_pin,
   output logic                      tx_busy,
   output logic                      tx_done
);

   localparam int LEN_W  = $clog2(DATA_W);
   // One extra bit so the bit counter can hold DATA_W-1 even when data_len is narrower.
   localparam int CNT_W  = LEN_W + 1;
   localparam int TICK_W = $clog2(OVERSAMPLE);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0]  LEN_MAX   = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic                stop2_q, stop2_d;
   logic                pin_d, busy_d, done_d;
   logic [CNT_W-1:0]    len_c;
   logic [DATA_W-1:0]   masked;
   logic                bit_end;

`ifdef UART_TX_PARITY_EN
   logic par_en_q, par_en_d;
   logic par_bit_q, par_bit_d;
`else
   logic unused_parity;
   assign unused_parity = parity_en ^ parity_odd;
`endif

   // Clamp the requested length and blank payload bits beyond it, so the
   // parity below only ever sees bits that actually go on the line.
   always_comb begin
      len_c = ({1'b0, data_len} > LEN_MAX) ? LEN_MAX : {1'b0, data_len};
      for (int i = 0; i < DATA_W; i++) begin
         masked[i] = tx_data[i] & (CNT_W'(i) <= len_c);
      end
   end

   assign bit_end = tick && (tick_cnt_q == TICK_LAST);

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      len_d      = len_q;
      stop2_d    = stop2_q;
      busy_d     = tx_busy;
      done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
`endif

      // Ticks are only counted while a frame is in flight.
      if (state_q != IDLE && tick) begin
         tick_cnt_d = bit_end ? '0 : tick_cnt_q + TICK_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (tx_start) begin
               state_d    = START;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               shreg_d    = masked;
               len_d      = len_c;
               stop2_d    = stop2;
               busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
               par_en_d   = parity_en;
               par_bit_d  = (^masked) ^ parity_odd;
`endif
            end
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == len_q) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = par_en_q ? PARITY : STOP;
`else
                  state_d   = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  shreg_d   = shreg_q >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
`endif
         STOP: begin
            if (bit_end) begin
               // bit_cnt doubles as the stop-bit index for the two-stop case.
               if (stop2_q && bit_cnt_q == '0) begin
                  bit_cnt_d = CNT_W'(1);
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the state being entered, so tx_pin is registered
      // yet changes on the same edge as the state.
      case (state_d)
         START:   pin_d = 1'b0;
         DATA:    pin_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  pin_d = par_bit_d;
`endif
         default: pin_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         len_q      <= '0;
         stop2_q    <= 1'b0;
         tx_pin     <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         len_q      <= len_d;
         stop2_q    <= stop2_d;
         tx_pin     <= pin_d;
         tx_busy    <= busy_d;
         tx_done    <= done_d;
`ifdef UART_TX_PARITY_EN
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg with OVERSAMPLE=4, DATA_W=8 and a tick every second clk.
// Line samples are taken once per counted tick, so each frame bit must show up 4 times.

module tb_uart_tx_cfg;

   localparam int OS = 4;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [2:0] data_len;
   logic       parity_en;
   logic       parity_odd;
   logic       stop2;
   logic       tx_pin;
   logic       tx_busy;
   logic       tx_done;

   int n_total = 0;
   int n_bad   = 0;

   uart_tx_cfg #(.DATA_W(8), .OVERSAMPLE(OS)) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .data_len   (data_len),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .tx_pin     (tx_pin),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   // line: expected line level per frame bit, LSB = start bit.
   typedef struct {
      logic [7:0]  data;
      logic [2:0]  len;
      logic        pen;
      logic        podd;
      logic        st2;
      int          nbits;
      logic [15:0] line;
   } vec_t;

   vec_t vt[6];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // tick changes just after posedge, high every second cycle.
   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1 tick = ~tick;
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic start_frame(input int vi);
      tx_data    = vt[vi].data;
      data_len   = vt[vi].len;
      parity_en  = vt[vi].pen;
      parity_odd = vt[vi].podd;
      stop2      = vt[vi].st2;
      tx_start   = 1'b1;
   endtask

   // Waits for the accepting edge, then logs one line sample per counted tick until tx_done.
   task automatic capture(input int vi, input bit disturb);
      logic samp[64];
      int   ns = 0;
      int   cyc = 0;
      int   dist_state = 0;
      bit   got_done = 0;
      bit   busy_low = 0;
      @(posedge clk);
      #1 tx_start = 1'b0;
      check($sformatf("f%0d_accept_pin", vi), tx_pin, 0);
      check($sformatf("f%0d_accept_busy", vi), tx_busy, 1);
      check($sformatf("f%0d_accept_done", vi), tx_done, 0);
      while (!got_done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (dist_state == 1) begin
            tx_start   = 1'b0;
            dist_state = 2;
         end
         if (tx_done) begin
            got_done = 1;
            check($sformatf("f%0d_done_busy", vi), tx_busy, 0);
            check($sformatf("f%0d_done_pin", vi), tx_pin, 1);
         end else begin
            if (!tx_busy) busy_low = 1;
            if (tick && ns < 64) begin
               samp[ns] = tx_pin;
               ns++;
            end
            if (disturb && dist_state == 0 && ns == 10) begin
               tx_start   = 1'b1;
               tx_data    = ~tx_data;
               data_len   = 3'd1;
               stop2      = ~stop2;
               dist_state = 1;
            end
         end
      end
      check($sformatf("f%0d_done_seen", vi), got_done, 1);
      check($sformatf("f%0d_busy_held", vi), busy_low, 0);
      check($sformatf("f%0d_tick_count", vi), ns, vt[vi].nbits * OS);
      for (int k = 0; k < ns && k < vt[vi].nbits * OS; k++) begin
         check($sformatf("f%0d_sample%0d", vi, k), samp[k], vt[vi].line[k / OS]);
      end
   endtask

   task automatic wait_ticks(input int n);
      int c = 0;
      int cyc = 0;
      while (c < n && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (tick) c++;
      end
      check("wait_ticks_bound", c, n);
   endtask

   initial begin
      int cnt;

      vt[0] = '{8'h55, 3'd7, 1'b0, 1'b0, 1'b0, 10, 16'h02AA};
      vt[1] = '{8'hA3, 3'd7, 1'b0, 1'b0, 1'b1, 11, 16'h0746};
      vt[2] = '{8'hE5, 3'd4, 1'b0, 1'b0, 1'b0,  7, 16'h004A};
      vt[3] = '{8'h00, 3'd0, 1'b0, 1'b0, 1'b0,  3, 16'h0004};
`ifdef UART_TX_PARITY_EN
      vt[4] = '{8'h07, 3'd4, 1'b1, 1'b0, 1'b0,  8, 16'h00CE};
      vt[5] = '{8'h03, 3'd7, 1'b1, 1'b1, 1'b0, 11, 16'h0606};
`else
      vt[4] = '{8'h07, 3'd4, 1'b1, 1'b0, 1'b0,  7, 16'h004E};
      vt[5] = '{8'h03, 3'd7, 1'b1, 1'b1, 1'b0, 10, 16'h0206};
`endif

      reset      = 1'b1;
      tx_start   = 1'b0;
      tx_data    = '0;
      data_len   = '0;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      stop2      = 1'b0;

      // Reset state, with a start request that must be held off by reset.
      repeat (2) @(posedge clk);
      #1 start_frame(0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_pin", tx_pin, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);

      // Start request already pending: first edge after release must accept it.
      @(negedge clk);
      reset = 1'b0;
      capture(0, 0);

      for (int i = 1; i < 6; i++) begin
         repeat (3) @(posedge clk);
         #1 start_frame(i);
         capture(i, 0);
      end

      // Two stop bits, then a back-to-back frame requested in the tx_done cycle.
      repeat (3) @(posedge clk);
      #1 start_frame(1);
      capture(1, 0);
      start_frame(2);
      capture(2, 0);

      // Mid-frame start pulse and input changes are ignored.
      repeat (3) @(posedge clk);
      #1 start_frame(0);
      capture(0, 1);
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (tx_busy || !tx_pin || tx_done) cnt++;
      end
      check("no_second_frame", cnt, 0);

      // Reset during data bit 3 aborts the frame without tx_done.
      repeat (3) @(posedge clk);
      #1 start_frame(0);
      @(posedge clk);
      #1 tx_start = 1'b0;
      wait_ticks(18);
      check("pre_reset_pin", tx_pin, 0);
      check("pre_reset_busy", tx_busy, 1);
      reset = 1'b1;
      #1;
      check("abort_pin", tx_pin, 1);
      check("abort_busy", tx_busy, 0);
      check("abort_done", tx_done, 0);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (tx_done || tx_busy || !tx_pin) cnt++;
      end
      check("abort_quiet", cnt, 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 start_frame(3);
      capture(3, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning tick pulses per bit period (legal 4..32).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tick  input  1  oversample strobe from the baud generator, one clk wide.
REQ-006 SHALL have port tx_start  input  1  request to send one frame.
REQ-007 SHALL have port tx_data  input  DATA_W  frame payload, LSB sent first.
REQ-008 SHALL have port data_len  input  $clog2(DATA_W)  data bits minus one; values >= DATA_W clamp to DATA_W-1.
REQ-009 SHALL have port parity_en  input  1  append a parity bit.
REQ-010 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-011 SHALL have port stop2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-012 SHALL have port tx_pin  output  1  registered serial line output.
REQ-013 SHALL have port tx_busy  output  1  high from accept until the frame ends.
REQ-014 SHALL have port tx_done  output  1  registered one-clk pulse at frame end.

Function
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-016 SHALL accept tx_start only in IDLE; tx_start in any other state is ignored without side effects.
REQ-017 SHALL capture tx_data, data_len, parity_en, parity_odd and stop2 at accept; input changes mid-frame have no effect.
REQ-018 SHALL drive tx_pin low on the clk edge that accepts tx_start, so the line falls one cycle after tx_start is sampled.
REQ-019 SHALL clear the tick counter at accept; every bit, including each stop bit, lasts exactly OVERSAMPLE tick pulses.
REQ-020 SHALL ignore tick in IDLE; a tick arriving in the same cycle as the accept is not counted.
REQ-021 SHALL send data_len+1 data bits in order tx_data[0] upward; tx_data bits above the frame length are ignored.
REQ-022 SHALL enter PARITY after DATA only when parity is enabled; otherwise DATA goes directly to STOP.
REQ-023 SHALL compute parity as the XOR of the transmitted data bits only, inverted when parity_odd = 1.
REQ-024 SHALL hold tx_pin high in STOP for OVERSAMPLE ticks, or 2*OVERSAMPLE ticks when the captured stop2 = 1.
REQ-025 SHALL, on the final stop tick, return to IDLE and assert tx_done for exactly the next clk cycle.
REQ-026 SHALL drive tx_busy low in that tx_done cycle and accept a tx_start in it, starting a back-to-back frame with no idle bit.
REQ-027 SHALL hold tx_pin high whenever the block is in IDLE.
REQ-028 SHALL size its counters so that neither the tick nor the bit counter wraps inside a legal frame at the maximum parameter values.

Reset
REQ-029 SHALL, while reset is high, force state to IDLE, tx_pin = 1, tx_busy = 0, tx_done = 0, and clear all counters and the shift register.
REQ-030 SHALL, when reset is asserted mid-frame, abort the frame immediately with no tx_done pulse; the line returns high asynchronously.
REQ-031 SHALL accept a tx_start in the first clk cycle after reset deasserts.

Configuration
REQ-032 SHALL compile in the parity logic and the PARITY state only when the macro UART_TX_PARITY_EN is defined.
REQ-033 SHALL, without UART_TX_PARITY_EN, keep the parity_en and parity_odd ports present but ignore them, never enter PARITY, and be otherwise identical.

Verification (OVERSAMPLE=4, DATA_W=8, tick every 2 clk)
REQ-034 SHALL check: data 0x55, data_len 7, no parity, stop2 0 -> line sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 ticks, one tx_done pulse.
REQ-035 SHALL check (macro defined): data 0x07, data_len 4, parity_en 1, parity_odd 0 -> data 1,1,1,0,0, then parity 1, then stop 1.
REQ-036 SHALL check: stop2 1 -> line high for 8 ticks before tx_done; a tx_start in the tx_done cycle yields a start bit on the next edge.
REQ-037 SHALL check: tx_start pulsed mid-frame and tx_data changed -> frame unchanged, no second frame follows.
REQ-038 SHALL check: reset asserted during DATA bit 3 -> tx_pin 1, tx_busy 0 and no tx_done; a new frame after release is correct.
REQ-039 SHALL check (macro undefined): parity_en 1 -> frame identical to parity_en 0.
